// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with blanking, syncs and line/frame pulses.
// Horizontal and vertical counters advance on pixel-clock-enable cycles.
// HBLK, VBLK and oRGB describe the pixel just consumed, so they lag HPOS by one pixel.
// HSYN and VSYN are aligned with HPOS/VPOS.
// Optional macro VTG_OFFSET_LATCH_EN: sync offsets are latched once per frame.
// Without the macro, HOFFS and VOFFS act immediately.
module video_timing_gen #(
    parameter int RGB_W    = 15,
    parameter int CW       = 9,
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int H_SYNC_B = 288,
    parameter int H_SYNC_W = 32,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 224,
    parameter int V_SYNC_B = 234,
    parameter int V_SYNC_W = 3,
    parameter int NARROW   = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             PCLK_EN,
    input  logic             H240,
    input  logic [3:0]       HOFFS,
    input  logic [3:0]       VOFFS,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CW-1:0]    HPOS,
    output logic [CW-1:0]    VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             LINE_START,
    output logic             FRAME_START
);
    // Signed width with headroom for the sync start plus or minus the offsets.
    localparam int SW = CW + 3;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] NAR_LO    = CW'(NARROW);
    localparam logic [CW-1:0] NAR_HI    = CW'(H_ACTIVE - NARROW);

    localparam logic signed [SW-1:0] H_TOTAL_S  = SW'(H_TOTAL);
    localparam logic signed [SW-1:0] V_TOTAL_S  = SW'(V_TOTAL);
    localparam logic signed [SW-1:0] H_SYNC_B_S = SW'(H_SYNC_B);
    localparam logic signed [SW-1:0] V_SYNC_B_S = SW'(V_SYNC_B);
    localparam logic signed [SW-1:0] H_SYNC_W_S = SW'(H_SYNC_W);
    localparam logic signed [SW-1:0] V_SYNC_W_S = SW'(V_SYNC_W);

    logic [CW-1:0] hcnt, vcnt, h_nxt, v_nxt;
    logic          h_wrap;
    logic          line_start, frame_start;
    logic          hblk_nxt, vblk_nxt, hsyn_nxt, vsyn_nxt;
    logic [3:0]    hoffs_eff, voffs_eff;

    logic signed [SW-1:0] hoff_ext, hs_raw, hsb, hd;
    logic signed [SW-1:0] voff_ext, vs_raw, vsb, vd;

    assign HPOS = hcnt;
    assign VPOS = vcnt;

    // Pulses are gated by reset so nothing fires while the counters are held at zero.
    assign line_start  = RESET_N & PCLK_EN & (hcnt == '0);
    assign frame_start = line_start & (vcnt == '0);
    assign LINE_START  = line_start;
    assign FRAME_START = frame_start;

`ifdef VTG_OFFSET_LATCH_EN
    logic [3:0] hoffs_q, voffs_q;

    // Shadow offsets, captured only in the first pixel of a frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hoffs_q <= '0;
            voffs_q <= '0;
        end else if (frame_start) begin
            hoffs_q <= HOFFS;
            voffs_q <= VOFFS;
        end
    end

    // The capturing pixel already uses the new values.
    assign hoffs_eff = frame_start ? HOFFS : hoffs_q;
    assign voffs_eff = frame_start ? VOFFS : voffs_q;
`else
    assign hoffs_eff = HOFFS;
    assign voffs_eff = VOFFS;
`endif

    // Next counter values: hcnt wraps at H_TOTAL, vcnt steps on every line wrap.
    always_comb begin
        h_wrap = (hcnt == H_LAST);
        h_nxt  = h_wrap ? '0 : hcnt + 1'b1;
        v_nxt  = vcnt;
        if (h_wrap) begin
            v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
    end

    // Blanking decisions for the pixel currently addressed by the counters.
    always_comb begin
        hblk_nxt = (hcnt >= H_ACT_C) || (H240 && ((hcnt < NAR_LO) || (hcnt >= NAR_HI)));
        vblk_nxt = (vcnt >= V_ACT_C);
    end

    // Horizontal sync window for the next pixel, start position taken modulo H_TOTAL.
    always_comb begin
        hoff_ext = {{(SW-4){hoffs_eff[3]}}, hoffs_eff};
        hs_raw   = H_SYNC_B_S + (hoff_ext <<< 1);
        hsb      = hs_raw;
        if (hs_raw[SW-1]) begin
            hsb = hs_raw + H_TOTAL_S;
        end else if (hs_raw >= H_TOTAL_S) begin
            hsb = hs_raw - H_TOTAL_S;
        end
        hd = $signed({{(SW-CW){1'b0}}, h_nxt}) - hsb;
        if (hd[SW-1]) begin
            hd = hd + H_TOTAL_S;
        end
        hsyn_nxt = !(hd < H_SYNC_W_S);
    end

    // Vertical sync window for the next line, start position taken modulo V_TOTAL.
    always_comb begin
        voff_ext = {{(SW-4){voffs_eff[3]}}, voffs_eff};
        vs_raw   = V_SYNC_B_S + voff_ext;
        vsb      = vs_raw;
        if (vs_raw[SW-1]) begin
            vsb = vs_raw + V_TOTAL_S;
        end else if (vs_raw >= V_TOTAL_S) begin
            vsb = vs_raw - V_TOTAL_S;
        end
        vd = $signed({{(SW-CW){1'b0}}, v_nxt}) - vsb;
        if (vd[SW-1]) begin
            vd = vd + V_TOTAL_S;
        end
        vsyn_nxt = !(vd < V_SYNC_W_S);
    end

    // Counters and registered video outputs; VSYN only moves on a line wrap.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt <= '0;
            vcnt <= '0;
            HBLK <= 1'b1;
            VBLK <= 1'b1;
            HSYN <= 1'b1;
            VSYN <= 1'b1;
            oRGB <= '0;
        end else if (PCLK_EN) begin
            hcnt <= h_nxt;
            vcnt <= v_nxt;
            HBLK <= hblk_nxt;
            VBLK <= vblk_nxt;
            oRGB <= (hblk_nxt || vblk_nxt) ? '0 : iRGB;
            HSYN <= hsyn_nxt;
            if (h_wrap) begin
                VSYN <= vsyn_nxt;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a reduced raster instance checked cycle by cycle against
// an arithmetic raster model, plus a default-geometry instance for the horizontal sync.
module tb_video_timing_gen;
  localparam int HT  = 48;
  localparam int HA  = 32;
  localparam int HSB = 36;
  localparam int HSW = 4;
  localparam int VT  = 20;
  localparam int VA  = 16;
  localparam int VSB = 17;
  localparam int VSW = 2;
  localparam int NW  = 2;

  logic        CLK;
  logic        RESET_N;
  logic        PCLK_EN;
  logic        H240;
  logic [3:0]  HOFFS;
  logic [3:0]  VOFFS;
  logic [14:0] iRGB;

  logic [8:0]  HPOS, VPOS;
  logic [14:0] oRGB;
  logic        HBLK, VBLK, HSYN, VSYN, LINE_START, FRAME_START;

  logic [8:0]  d_hpos, d_vpos;
  logic [14:0] d_rgb;
  logic        d_hblk, d_vblk, d_hsyn, d_vsyn, d_line, d_frame;

  int n_checks;
  int n_errs;

  // reference raster state
  int          m_h, m_v, lat_h, lat_v;
  logic [8:0]  e_hpos, e_vpos, o_hpos, o_vpos;
  logic        e_line, e_frame, o_line, o_frame;
  logic        e_hblk, e_vblk, e_hsyn, e_vsyn;
  logic [14:0] e_rgb;

  video_timing_gen #(
    .RGB_W(15), .CW(9),
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_B(HSB), .H_SYNC_W(HSW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_B(VSB), .V_SYNC_W(VSW),
    .NARROW(NW)
  ) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .PCLK_EN(PCLK_EN), .H240(H240),
    .HOFFS(HOFFS), .VOFFS(VOFFS), .iRGB(iRGB),
    .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB),
    .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START)
  );

  video_timing_gen u_def (
    .CLK(CLK), .RESET_N(RESET_N), .PCLK_EN(PCLK_EN), .H240(H240),
    .HOFFS(HOFFS), .VOFFS(VOFFS), .iRGB(iRGB),
    .HPOS(d_hpos), .VPOS(d_vpos), .oRGB(d_rgb),
    .HBLK(d_hblk), .VBLK(d_vblk), .HSYN(d_hsyn), .VSYN(d_vsyn),
    .LINE_START(d_line), .FRAME_START(d_frame)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int wmod(input int x, input int m);
    return ((x % m) + m) % m;
  endfunction

  function automatic bit in_hsync(input int h, input int off);
    int s;
    s = wmod(HSB + 2 * off, HT);
    return wmod(h - s, HT) < HSW;
  endfunction

  function automatic bit in_vsync(input int v, input int off);
    int s;
    s = wmod(VSB + off, VT);
    return wmod(v - s, VT) < VSW;
  endfunction

  function automatic bit hblank(input int h, input bit nar);
    return (h >= HA) || (nar && ((h < NW) || (h >= HA - NW)));
  endfunction

  task automatic reset_model();
    m_h = 0; m_v = 0; lat_h = 0; lat_v = 0;
    e_hblk = 1'b1; e_vblk = 1'b1; e_hsyn = 1'b1; e_vsyn = 1'b1; e_rgb = '0;
  endtask

  // Pulse reset; returns just after a rising edge with reset released.
  task automatic do_reset();
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    PCLK_EN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    reset_model();
  endtask

  // One CLK: observe combinational outputs mid-cycle, then advance the model on the edge.
  task automatic tick(input bit en);
    int eh, ev;
    PCLK_EN = en;
    e_hpos  = 9'(m_h);
    e_vpos  = 9'(m_v);
    e_line  = en && (m_h == 0);
    e_frame = en && (m_h == 0) && (m_v == 0);
    @(negedge CLK);
    o_hpos = HPOS; o_vpos = VPOS; o_line = LINE_START; o_frame = FRAME_START;
    @(posedge CLK);
    if (en) begin
`ifdef VTG_OFFSET_LATCH_EN
      if (m_h == 0 && m_v == 0) begin
        lat_h = $signed(HOFFS);
        lat_v = $signed(VOFFS);
      end
      eh = lat_h; ev = lat_v;
`else
      eh = $signed(HOFFS); ev = $signed(VOFFS);
`endif
      e_hblk = hblank(m_h, H240);
      e_vblk = (m_v >= VA);
      e_rgb  = (e_hblk || e_vblk) ? 15'd0 : iRGB;
      m_h = (m_h + 1) % HT;
      if (m_h == 0) m_v = (m_v + 1) % VT;
      e_hsyn = !in_hsync(m_h, eh);
      if (m_h == 0) e_vsyn = !in_vsync(m_v, ev);
    end
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; PCLK_EN = 1'b1; H240 = 1'b0; HOFFS = '0; VOFFS = '0; iRGB = 15'h1234;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (HPOS !== 9'd0) begin n_errs++; $display("FAIL reset_hpos got %0d exp 0", HPOS); end
    n_checks++; if (VPOS !== 9'd0) begin n_errs++; $display("FAIL reset_vpos got %0d exp 0", VPOS); end
    n_checks++; if (HBLK !== 1'b1) begin n_errs++; $display("FAIL reset_hblk got %b exp 1", HBLK); end
    n_checks++; if (VBLK !== 1'b1) begin n_errs++; $display("FAIL reset_vblk got %b exp 1", VBLK); end
    n_checks++; if (HSYN !== 1'b1) begin n_errs++; $display("FAIL reset_hsyn got %b exp 1", HSYN); end
    n_checks++; if (VSYN !== 1'b1) begin n_errs++; $display("FAIL reset_vsyn got %b exp 1", VSYN); end
    n_checks++; if (oRGB !== 15'd0) begin n_errs++; $display("FAIL reset_rgb got %h exp 0", oRGB); end
    n_checks++; if (LINE_START !== 1'b0) begin n_errs++; $display("FAIL reset_line got %b exp 0", LINE_START); end
    n_checks++; if (FRAME_START !== 1'b0) begin n_errs++; $display("FAIL reset_frame got %b exp 0", FRAME_START); end
    RESET_N = 1'b1;
    reset_model();
    tick(1'b1);
    n_checks++; if (o_frame !== 1'b1) begin n_errs++; $display("FAIL first_frame_start got %b exp 1", o_frame); end
    n_checks++; if (o_line !== 1'b1) begin n_errs++; $display("FAIL first_line_start got %b exp 1", o_line); end
    n_checks++; if (HPOS !== 9'd1) begin n_errs++; $display("FAIL first_step_hpos got %0d exp 1", HPOS); end
    n_checks++; if (HBLK !== 1'b0) begin n_errs++; $display("FAIL first_step_hblk got %b exp 0", HBLK); end
  endtask

  // Random-data stream compared against the model every CLK.
  // per: 0 = random enable, k = enable every k-th CLK.
  task automatic test_stream(input int n, input int per, input bit roffs, input bit rh240);
    int last_l, last_f;
    bit en;
    last_l = -1; last_f = -1;
    for (int i = 0; i < n; i++) begin
      iRGB = 15'($urandom);
      if (roffs && $urandom_range(0, 63) == 0) HOFFS = 4'($urandom);
      if (roffs && $urandom_range(0, 63) == 0) VOFFS = 4'($urandom);
      if (rh240 && $urandom_range(0, 99) == 0) H240 = ~H240;
      en = (per == 0) ? ($urandom_range(0, 3) != 0) : ((i % per) == 0);
      tick(en);
      n_checks++; if (o_hpos !== e_hpos) begin n_errs++; $display("FAIL hpos t=%0t got %0d exp %0d", $time, o_hpos, e_hpos); end
      n_checks++; if (o_vpos !== e_vpos) begin n_errs++; $display("FAIL vpos t=%0t got %0d exp %0d", $time, o_vpos, e_vpos); end
      n_checks++; if (o_line !== e_line) begin n_errs++; $display("FAIL line_start t=%0t got %b exp %b", $time, o_line, e_line); end
      n_checks++; if (o_frame !== e_frame) begin n_errs++; $display("FAIL frame_start t=%0t got %b exp %b", $time, o_frame, e_frame); end
      n_checks++; if (HBLK !== e_hblk) begin n_errs++; $display("FAIL hblk t=%0t got %b exp %b", $time, HBLK, e_hblk); end
      n_checks++; if (VBLK !== e_vblk) begin n_errs++; $display("FAIL vblk t=%0t got %b exp %b", $time, VBLK, e_vblk); end
      n_checks++; if (oRGB !== e_rgb) begin n_errs++; $display("FAIL orgb t=%0t got %h exp %h", $time, oRGB, e_rgb); end
      n_checks++; if (HSYN !== e_hsyn) begin n_errs++; $display("FAIL hsyn t=%0t hpos=%0d got %b exp %b", $time, m_h, HSYN, e_hsyn); end
      n_checks++; if (VSYN !== e_vsyn) begin n_errs++; $display("FAIL vsyn t=%0t vpos=%0d got %b exp %b", $time, m_v, VSYN, e_vsyn); end
      if (!roffs) begin
        n_checks++;
        if (HSYN !== !(m_h >= HSB && m_h < HSB + HSW)) begin
          n_errs++; $display("FAIL hsyn_window hpos=%0d got %b", m_h, HSYN);
        end
        n_checks++;
        if (VSYN !== !(m_v >= VSB && m_v < VSB + VSW)) begin
          n_errs++; $display("FAIL vsyn_window vpos=%0d got %b", m_v, VSYN);
        end
      end
      if (o_line === 1'b1) begin
        if (per > 0 && last_l >= 0) begin
          n_checks++;
          if (i - last_l != HT * per) begin n_errs++; $display("FAIL line_period got %0d exp %0d", i - last_l, HT * per); end
        end
        last_l = i;
      end
      if (o_frame === 1'b1) begin
        if (per > 0 && last_f >= 0) begin
          n_checks++;
          if (i - last_f != HT * VT * per) begin n_errs++; $display("FAIL frame_period got %0d exp %0d", i - last_f, HT * VT * per); end
        end
        last_f = i;
      end
    end
  endtask

  task automatic test_free_run();
    H240 = 1'b0; HOFFS = '0; VOFFS = '0;
    do_reset();
    test_stream(HT * VT + HT + 4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_narrow();
    int prev, pv;
    logic exp_hb;
    logic [14:0] exp_rgb;
    H240 = 1'b1; iRGB = 15'h7FFF;
    for (int i = 0; i < 3 * HT; i++) begin
      tick(1'b1);
      prev = (m_h + HT - 1) % HT;
      pv = (m_h == 0) ? (m_v + VT - 1) % VT : m_v;
      exp_hb = (prev < NW) || (prev >= HA - NW);
      exp_rgb = (exp_hb || pv >= VA) ? 15'd0 : 15'h7FFF;
      n_checks++; if (HBLK !== exp_hb) begin n_errs++; $display("FAIL narrow_hblk pix=%0d got %b exp %b", prev, HBLK, exp_hb); end
      n_checks++; if (oRGB !== exp_rgb) begin n_errs++; $display("FAIL narrow_rgb pix=%0d got %h exp %h", prev, oRGB, exp_rgb); end
    end
    H240 = 1'b0;
  endtask

  task automatic test_offsets();
    HOFFS = 4'd7; VOFFS = 4'd7;
    do_reset();
    test_stream(3 * HT * VT, 0, 1'b1, 1'b1);
  endtask

  task automatic test_sparse_en();
    H240 = 1'b0; HOFFS = '0; VOFFS = '0;
    do_reset();
    test_stream(4 * HT * VT + 4 * HT + 8, 4, 1'b0, 1'b0);
  endtask

  // Full-size geometry: horizontal sync position for several offsets over two lines.
  task automatic test_default_geometry();
    int offs_tab[3];
    int dh, s;
    offs_tab = '{0, 7, -8};
    for (int k = 0; k < 3; k++) begin
      HOFFS = 4'(offs_tab[k]); VOFFS = '0; H240 = 1'b0;
      do_reset();
      PCLK_EN = 1'b1;
      dh = 0;
      s = 288 + 2 * offs_tab[k];
      for (int c = 0; c < 2 * 384 + 8; c++) begin
        @(negedge CLK);
        n_checks++; if (d_hpos !== 9'(dh)) begin n_errs++; $display("FAIL def_hpos got %0d exp %0d", d_hpos, dh); end
        n_checks++;
        if (d_hsyn !== !(dh >= s && dh < s + 32)) begin
          n_errs++; $display("FAIL def_hsyn off=%0d hpos=%0d got %b", offs_tab[k], dh, d_hsyn);
        end
        n_checks++; if (d_line !== (dh == 0)) begin n_errs++; $display("FAIL def_line hpos=%0d got %b", dh, d_line); end
        @(posedge CLK); #1;
        dh = (dh + 1) % 384;
      end
    end
    HOFFS = '0;
  endtask

  task automatic test_async_reset();
    int guard;
    H240 = 1'b0; HOFFS = '0; VOFFS = '0;
    do_reset();
    guard = 0;
    while (m_h != HSB + 1 && guard < 2 * HT) begin
      tick(1'b1);
      guard++;
    end
    n_checks++; if (guard >= 2 * HT) begin n_errs++; $display("FAIL async_reach got %0d exp %0d", m_h, HSB + 1); end
    n_checks++; if (HSYN !== 1'b0) begin n_errs++; $display("FAIL async_pre_hsyn got %b exp 0", HSYN); end
    #2;
    RESET_N = 1'b0;
    #1;
    n_checks++; if (HSYN !== 1'b1) begin n_errs++; $display("FAIL async_hsyn got %b exp 1", HSYN); end
    n_checks++; if (HPOS !== 9'd0) begin n_errs++; $display("FAIL async_hpos got %0d exp 0", HPOS); end
    n_checks++; if (HBLK !== 1'b1) begin n_errs++; $display("FAIL async_hblk got %b exp 1", HBLK); end
    n_checks++; if (oRGB !== 15'd0) begin n_errs++; $display("FAIL async_rgb got %h exp 0", oRGB); end
    n_checks++; if (LINE_START !== 1'b0) begin n_errs++; $display("FAIL async_line got %b exp 0", LINE_START); end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    reset_model();
    tick(1'b1);
    n_checks++; if (o_frame !== 1'b1) begin n_errs++; $display("FAIL async_restart_frame got %b exp 1", o_frame); end
    for (int i = 0; i < HT + 2; i++) begin
      tick(1'b1);
      n_checks++; if (HSYN !== e_hsyn) begin n_errs++; $display("FAIL async_after_hsyn hpos=%0d got %b exp %b", m_h, HSYN, e_hsyn); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    test_reset();
    test_free_run();
    test_narrow();
    test_offsets();
    test_sparse_en();
    test_default_geometry();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
